// File: rtl/dram_audio_demux_if.sv
// ============================================================================
// Module   : dram_audio_demux_if
// Purpose  : AXIS-style chunk stream carrying DRAM audio chunks and metadata.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dram_audio_demux_if #(
  parameter int SAMPLE_WIDTH      = 16,
  parameter int SAMPLES_PER_CHUNK = 8,
  parameter int ADDR_WIDTH        = 24,
  parameter int PERIOD_WIDTH      = 14
);
  logic                                      chunk_tvalid;
  logic                                      chunk_tready;
  logic [SAMPLE_WIDTH*SAMPLES_PER_CHUNK-1:0] chunk_tdata;
  logic [ADDR_WIDTH-1:0]                     chunk_addr;
  logic [PERIOD_WIDTH-1:0]                   chunk_period;

  modport master (
    output chunk_tvalid, chunk_tdata, chunk_addr, chunk_period,
    input  chunk_tready
  );

  modport slave (
    input  chunk_tvalid, chunk_tdata, chunk_addr, chunk_period,
    output chunk_tready
  );
endinterface

`default_nettype wire

// File: rtl/dram_audio_demux.sv
// ============================================================================
// Module   : dram_audio_demux
// Purpose  : Routes DRAM sample chunks to per-instrument FIFOs by address range
//            and plays one sample per instrument on every sample-period tick.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dram_audio_demux #(
  parameter int INSTRUMENT_COUNT  = 8,
  parameter int SAMPLE_WIDTH      = 16,
  parameter int SAMPLES_PER_CHUNK = 8,
  parameter int ADDR_WIDTH        = 24,
  parameter int PERIOD_WIDTH      = 14,
  parameter int FIFO_DEPTH        = 4
) (
  input  wire logic                                            clk,
  input  wire logic                                            rst,
  input  wire logic [INSTRUMENT_COUNT:0][ADDR_WIDTH-1:0]       addr_offsets,
  input  wire logic                                            addr_offsets_valid,
  dram_audio_demux_if.slave                                    chunk,
  input  wire logic [INSTRUMENT_COUNT-1:0]                     flush,
  output logic      [INSTRUMENT_COUNT-1:0][SAMPLE_WIDTH-1:0]   instrument_samples,
  output logic                                                 sample_tick,
  output logic      [INSTRUMENT_COUNT-1:0]                     underrun,
  output logic      [INSTRUMENT_COUNT-1:0]                     chunk_need,
  output logic      [15:0]                                     drop_count,
  output logic      [PERIOD_WIDTH-1:0]                         sample_period
);

  localparam int c_CHUNK_W = SAMPLE_WIDTH * SAMPLES_PER_CHUNK;
  localparam int c_CH_W    = (INSTRUMENT_COUNT > 1) ? $clog2(INSTRUMENT_COUNT) : 1;
  localparam int c_PTR_W   = $clog2(FIFO_DEPTH);
  localparam int c_OCC_W   = $clog2(FIFO_DEPTH + 1);
  localparam int c_IDX_W   = (SAMPLES_PER_CHUNK > 1) ? $clog2(SAMPLES_PER_CHUNK) : 1;

  localparam logic [PERIOD_WIDTH-1:0] c_PERIOD_ONE = PERIOD_WIDTH'(1);
  localparam logic [c_PTR_W-1:0]      c_PTR_ONE    = c_PTR_W'(1);
  localparam logic [c_OCC_W-1:0]      c_OCC_ONE    = c_OCC_W'(1);
  localparam logic [c_OCC_W-1:0]      c_OCC_FULL   = c_OCC_W'(FIFO_DEPTH);
  localparam logic [c_OCC_W-1:0]      c_OCC_HALF   = c_OCC_W'(FIFO_DEPTH / 2);
  localparam logic [c_IDX_W-1:0]      c_IDX_ONE    = c_IDX_W'(1);
  localparam logic [c_IDX_W-1:0]      c_IDX_LAST   = c_IDX_W'(SAMPLES_PER_CHUNK - 1);

  logic                        w_hit_any;
  logic [c_CH_W-1:0]           w_hit_idx;
  logic [INSTRUMENT_COUNT-1:0] w_full;
  logic                        w_tready;
  logic                        w_accept;
  logic                        w_push_any;
  logic                        w_drop;
  logic                        w_tick;
  logic [PERIOD_WIDTH-1:0]     r_cnt;

  // Scan downwards so the lowest matching channel wins on overlapping ranges.
  always_comb begin
    w_hit_any = 1'b0;
    w_hit_idx = '0;
    for (int i = INSTRUMENT_COUNT - 1; i >= 0; i--) begin
      if (addr_offsets_valid && (chunk.chunk_addr >= addr_offsets[i]) &&
          (chunk.chunk_addr < addr_offsets[i+1])) begin
        w_hit_any = 1'b1;
        w_hit_idx = c_CH_W'(i);
      end
    end
  end

  always_comb begin
    w_tready = 1'b0;
    if (addr_offsets_valid) begin
      if (w_hit_any) w_tready = !w_full[w_hit_idx] && !flush[w_hit_idx];
      else           w_tready = 1'b1;
    end
  end

  assign chunk.chunk_tready = w_tready;
  assign w_accept   = chunk.chunk_tvalid && w_tready;
  assign w_push_any = w_accept && w_hit_any;
  assign w_drop     = w_accept && !w_hit_any;
  assign w_tick     = (sample_period != '0) && (r_cnt >= (sample_period - c_PERIOD_ONE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt         <= '0;
      sample_period <= '0;
      sample_tick   <= 1'b0;
      drop_count    <= '0;
    end else begin
      sample_tick <= w_tick;
      if (w_push_any) sample_period <= chunk.chunk_period;
      // A '>=' compare lets a shrinking period fire immediately instead of wrapping.
      if ((sample_period == '0) || w_tick) r_cnt <= '0;
      else                                 r_cnt <= r_cnt + c_PERIOD_ONE;
      if (w_drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
    end
  end

  for (genvar i = 0; i < INSTRUMENT_COUNT; i++) begin : g_channel
    localparam logic [c_CH_W-1:0] c_ID = c_CH_W'(i);

    logic [c_CHUNK_W-1:0]    r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]      r_wr;
    logic [c_PTR_W-1:0]      r_rd;
    logic [c_OCC_W-1:0]      r_occ;
    logic [c_IDX_W-1:0]      r_idx;
    logic [SAMPLE_WIDTH-1:0] r_sample;
    logic                    r_underrun;
    logic                    r_need;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_empty;
    logic [c_OCC_W-1:0]      w_occ_next;
    logic [SAMPLE_WIDTH-1:0] w_cur;

    assign w_empty   = (r_occ == '0);
    assign w_full[i] = (r_occ == c_OCC_FULL);
    assign w_push    = w_push_any && (w_hit_idx == c_ID) && !flush[i];
    assign w_pop     = w_tick && !w_empty && (r_idx == c_IDX_LAST);
    assign w_cur     = r_mem[r_rd][r_idx*SAMPLE_WIDTH +: SAMPLE_WIDTH];

    always_comb begin
      w_occ_next = r_occ;
      if (flush[i])             w_occ_next = '0;
      else if (w_push && !w_pop) w_occ_next = r_occ + c_OCC_ONE;
      else if (!w_push && w_pop) w_occ_next = r_occ - c_OCC_ONE;
    end

    always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= chunk.chunk_tdata;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_wr       <= '0;
        r_rd       <= '0;
        r_occ      <= '0;
        r_idx      <= '0;
        r_sample   <= '0;
        r_underrun <= 1'b0;
        r_need     <= 1'b1;
      end else begin
        r_underrun <= 1'b0;
        r_occ      <= w_occ_next;
        r_need     <= (w_occ_next < c_OCC_HALF);
        if (flush[i]) begin
          r_wr     <= '0;
          r_rd     <= '0;
          r_idx    <= '0;
          r_sample <= '0;
        end else begin
          if (w_push) r_wr <= r_wr + c_PTR_ONE;
          if (w_tick) begin
            if (!w_empty) begin
              r_sample <= w_cur;
              if (w_pop) begin
                r_rd  <= r_rd + c_PTR_ONE;
                r_idx <= '0;
              end else begin
                r_idx <= r_idx + c_IDX_ONE;
              end
            end else begin
              r_sample   <= '0;
              r_underrun <= 1'b1;
            end
          end
        end
      end
    end

    assign instrument_samples[i] = r_sample;
    assign underrun[i]           = r_underrun;
    assign chunk_need[i]         = r_need;
  end

endmodule

`default_nettype wire

// File: tb/tb_dram_audio_demux.sv
// ============================================================================
// Module   : tb_dram_audio_demux
// Purpose  : Directed self-checking bench for dram_audio_demux.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dram_audio_demux;

  localparam int c_N   = 8;
  localparam int c_SW  = 16;
  localparam int c_SPC = 8;
  localparam int c_AW  = 24;
  localparam int c_PW  = 14;

  logic                         clk;
  logic                         rst;
  logic [c_N:0][c_AW-1:0]       addr_offsets;
  logic                         addr_offsets_valid;
  logic [c_N-1:0]               flush;
  logic [c_N-1:0][c_SW-1:0]     instrument_samples;
  logic                         sample_tick;
  logic [c_N-1:0]               underrun;
  logic [c_N-1:0]               chunk_need;
  logic [15:0]                  drop_count;
  logic [c_PW-1:0]              sample_period;

  int n_cmp  = 0;
  int n_fail = 0;

  dram_audio_demux_if #(
    .SAMPLE_WIDTH(c_SW), .SAMPLES_PER_CHUNK(c_SPC), .ADDR_WIDTH(c_AW), .PERIOD_WIDTH(c_PW)
  ) chunk_bus ();

  dram_audio_demux #(
    .INSTRUMENT_COUNT(c_N), .SAMPLE_WIDTH(c_SW), .SAMPLES_PER_CHUNK(c_SPC),
    .ADDR_WIDTH(c_AW), .PERIOD_WIDTH(c_PW), .FIFO_DEPTH(4)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .addr_offsets       (addr_offsets),
    .addr_offsets_valid (addr_offsets_valid),
    .chunk              (chunk_bus),
    .flush              (flush),
    .instrument_samples (instrument_samples),
    .sample_tick        (sample_tick),
    .underrun           (underrun),
    .chunk_need         (chunk_need),
    .drop_count         (drop_count),
    .sample_period      (sample_period)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [c_SW*c_SPC-1:0] mk_chunk(input logic [15:0] base);
    logic [c_SW*c_SPC-1:0] d;
    for (int k = 0; k < c_SPC; k++) d[k*c_SW +: c_SW] = base + 16'(k);
    return d;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
  endtask

  task automatic send_chunk(input logic [c_AW-1:0] addr, input logic [c_PW-1:0] per,
                            input logic [15:0] base);
    logic ok;
    ok = 1'b0;
    chunk_bus.chunk_tvalid = 1'b1;
    chunk_bus.chunk_addr   = addr;
    chunk_bus.chunk_period = per;
    chunk_bus.chunk_tdata  = mk_chunk(base);
    for (int c = 0; c < 20; c++) begin
      #1;
      if (chunk_bus.chunk_tready) begin
        cyc();
        ok = 1'b1;
        break;
      end
      cyc();
    end
    chunk_bus.chunk_tvalid = 1'b0;
    check("send_accepted", 64'(ok), 64'd1);
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!sample_tick && n < 200);
    check("tick_seen", 64'(sample_tick), 64'd1);
  endtask

  initial begin
    int n;
    int ticks;
    logic [15:0] first_ch0;

    rst = 1'b0;
    addr_offsets_valid = 1'b1;
    flush = '0;
    for (int i = 0; i <= c_N; i++) addr_offsets[i] = c_AW'(100 * i);
    chunk_bus.chunk_tvalid = 1'b0;
    chunk_bus.chunk_addr   = '0;
    chunk_bus.chunk_period = '0;
    chunk_bus.chunk_tdata  = '0;
    #12 rst = 1'b1;
    cyc();

    // Reset state
    check("rst_need", 64'(chunk_need), 64'hFF);
    check("rst_drop", 64'(drop_count), 64'd0);
    check("rst_period", 64'(sample_period), 64'd0);
    check("rst_tick", 64'(sample_tick), 64'd0);
    check("rst_underrun", 64'(underrun), 64'd0);
    check("rst_samples", 64'(instrument_samples[1]), 64'd0);

    // Single chunk to ch1, period 4: samples 1..8 then underrun
    send_chunk(24'd150, 14'd4, 16'd1);
    check("t1_period", 64'(sample_period), 64'd4);
    for (int k = 0; k < 9; k++) begin
      wait_tick(n);
      check("t1_gap", 64'(n), 64'd4);
      if (k < 8) begin
        check("t1_sample", 64'(instrument_samples[1]), 64'(k + 1));
        check("t1_underrun", 64'(underrun), 64'hFD);
      end else begin
        check("t1_sample_empty", 64'(instrument_samples[1]), 64'd0);
        check("t1_underrun_empty", 64'(underrun), 64'hFF);
      end
    end
    cyc();
    check("t1_underrun_pulse", 64'(underrun), 64'd0);
    check("t1_tick_pulse", 64'(sample_tick), 64'd0);

    // Offsets table invalid stalls the stream
    addr_offsets_valid = 1'b0;
    chunk_bus.chunk_tvalid = 1'b1;
    chunk_bus.chunk_addr   = 24'd450;
    chunk_bus.chunk_period = 14'd9;
    chunk_bus.chunk_tdata  = mk_chunk(16'h0450);
    #1;
    check("t5_stall_ready", 64'(chunk_bus.chunk_tready), 64'd0);
    cyc(); cyc(); cyc();
    check("t5_stall_period", 64'(sample_period), 64'd4);
    check("t5_stall_drop", 64'(drop_count), 64'd0);
    addr_offsets_valid = 1'b1;
    #1;
    check("t5_ready", 64'(chunk_bus.chunk_tready), 64'd1);
    cyc();
    chunk_bus.chunk_tvalid = 1'b0;
    check("t5_accepted_period", 64'(sample_period), 64'd9);

    // Fill ch0 with period 0 (no ticks)
    do_reset();
    send_chunk(24'd10, 14'd0, 16'h0100);
    check("t3_need_1", 64'(chunk_need[0]), 64'd1);
    send_chunk(24'd10, 14'd0, 16'h0200);
    check("t3_need_2", 64'(chunk_need[0]), 64'd0);
    send_chunk(24'd10, 14'd0, 16'h0300);
    send_chunk(24'd10, 14'd0, 16'h0400);
    chunk_bus.chunk_tvalid = 1'b1;
    chunk_bus.chunk_addr   = 24'd20;
    chunk_bus.chunk_period = 14'd0;
    #1;
    check("t3_full_ready", 64'(chunk_bus.chunk_tready), 64'd0);
    cyc(); cyc();
    check("t3_full_ready_hold", 64'(chunk_bus.chunk_tready), 64'd0);
    chunk_bus.chunk_tvalid = 1'b0;
    check("t3_need_full", 64'(chunk_need[0]), 64'd0);
    send_chunk(24'd550, 14'd2, 16'h0500);
    ticks = 0;
    first_ch0 = 16'hDEAD;
    for (int c = 0; c < 300; c++) begin
      cyc();
      if (sample_tick) begin
        ticks++;
        if (ticks == 1) first_ch0 = instrument_samples[0];
      end
      if (chunk_need[0]) break;
    end
    check("t3_first_ch0", 64'(first_ch0), 64'h0100);
    check("t3_need_back", 64'(chunk_need[0]), 64'd1);
    check("t3_ticks_to_need", 64'(ticks), 64'd24);

    // Flush ch2 mid-chunk while ch3 keeps playing
    do_reset();
    send_chunk(24'd250, 14'd4, 16'h2000);
    send_chunk(24'd350, 14'd4, 16'h3000);
    wait_tick(n);
    wait_tick(n);
    wait_tick(n);
    check("t4_ch2_pre", 64'(instrument_samples[2]), 64'h2002);
    check("t4_ch3_pre", 64'(instrument_samples[3]), 64'h3002);
    flush = 8'b0000_0100;
    chunk_bus.chunk_tvalid = 1'b1;
    chunk_bus.chunk_addr   = 24'd260;
    chunk_bus.chunk_tdata  = mk_chunk(16'h2800);
    #1;
    check("t4_flush_ready", 64'(chunk_bus.chunk_tready), 64'd0);
    cyc();
    flush = '0;
    chunk_bus.chunk_tvalid = 1'b0;
    check("t4_ch2_flushed", 64'(instrument_samples[2]), 64'd0);
    check("t4_ch3_hold", 64'(instrument_samples[3]), 64'h3002);
    check("t4_flush_underrun", 64'(underrun), 64'd0);
    check("t4_need2", 64'(chunk_need[2]), 64'd1);
    wait_tick(n);
    check("t4_ch2_empty", 64'(instrument_samples[2]), 64'd0);
    check("t4_ch2_underrun", 64'(underrun[2]), 64'd1);
    check("t4_ch3_next", 64'(instrument_samples[3]), 64'h3003);

    // Asynchronous reset between clock edges
    do_reset();
    send_chunk(24'd120, 14'd4, 16'h0010);
    wait_tick(n);
    wait_tick(n);
    check("t6_pre_sample", 64'(instrument_samples[1]), 64'h0011);
    #3 rst = 1'b0;
    #1;
    check("t6_async_sample", 64'(instrument_samples[1]), 64'd0);
    check("t6_async_period", 64'(sample_period), 64'd0);
    check("t6_async_need", 64'(chunk_need), 64'hFF);
    #2 rst = 1'b1;
    cyc();
    ticks = 0;
    for (int c = 0; c < 20; c++) begin
      cyc();
      if (sample_tick) ticks++;
    end
    check("t6_no_ticks", 64'(ticks), 64'd0);
    send_chunk(24'd420, 14'd3, 16'h0040);
    wait_tick(n);
    check("t6_gap", 64'(n), 64'd3);
    check("t6_ch4", 64'(instrument_samples[4]), 64'h0040);
    check("t6_ch1_discarded", 64'(underrun[1]), 64'd1);

    // Unmatched chunks and drop-counter saturation
    do_reset();
    chunk_bus.chunk_tvalid = 1'b1;
    chunk_bus.chunk_addr   = 24'd800;
    chunk_bus.chunk_period = 14'd7;
    #1;
    check("t2_drop_ready", 64'(chunk_bus.chunk_tready), 64'd1);
    cyc();
    chunk_bus.chunk_tvalid = 1'b0;
    check("t2_drop_1", 64'(drop_count), 64'd1);
    check("t2_drop_period", 64'(sample_period), 64'd0);
    send_chunk(24'd799, 14'd5, 16'h0700);
    check("t2_upper_hit_drop", 64'(drop_count), 64'd1);
    check("t2_upper_hit_period", 64'(sample_period), 64'd5);
    send_chunk(24'd100, 14'd6, 16'h0100);
    check("t2_lower_hit_period", 64'(sample_period), 64'd6);
    chunk_bus.chunk_tvalid = 1'b1;
    chunk_bus.chunk_addr   = 24'd900;
    for (int c = 0; c < 65533; c++) cyc();
    check("t2_drop_near", 64'(drop_count), 64'd65534);
    cyc();
    check("t2_drop_sat", 64'(drop_count), 64'd65535);
    for (int c = 0; c < 5; c++) cyc();
    check("t2_drop_hold", 64'(drop_count), 64'd65535);
    check("t2_sat_ready", 64'(chunk_bus.chunk_tready), 64'd1);
    chunk_bus.chunk_tvalid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
